// File: rtl/serial_digit_code_conv.sv
`timescale 1ns/1ps
// Bit-serial LSB-first digit code converter: adds or subtracts a fixed offset per digit
// (BCD <-> Excess-3 by default), with parallel digit result and digit/word error flags.
//
// state    | meaning
// ST_IDLE  | waiting for bit 0 of a digit (bit index 0), mode taken live from i_mode
// ST_SHIFT | bits 1..DIGIT_W-1 of a digit in flight, mode held in r_mode
module serial_digit_code_conv #(
   parameter int DIGIT_W    = 4,
   parameter int OFFSET     = 3,
   parameter int RADIX      = 10,
   parameter int NUM_DIGITS = 4,
   localparam int BIT_W     = $clog2(DIGIT_W),
   localparam int DIDX_W    = $clog2(NUM_DIGITS)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic               i_mode,
   input  logic               i_x,
   output logic               o_z,
   output logic [BIT_W-1:0]   o_bit_idx,
   output logic [DIDX_W-1:0]  o_digit_idx,
   output logic               o_digit_done,
   output logic [DIGIT_W-1:0] o_digit_out,
   output logic               o_digit_err,
   output logic               o_word_done,
   output logic               o_word_err
);

   localparam logic [DIGIT_W-1:0] OFFS_V   = DIGIT_W'(OFFSET);
   localparam logic [DIGIT_W:0]   RADIX_V  = (DIGIT_W+1)'(RADIX);
   localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(DIGIT_W-1);
   localparam logic [DIDX_W-1:0]  LAST_DIG = DIDX_W'(NUM_DIGITS-1);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   state_t               r_state, w_state_nxt;
   logic [BIT_W-1:0]     r_bit_idx;
   logic [DIDX_W-1:0]    r_digit_idx;
   logic                 r_carry;
   logic                 r_mode;
   logic [DIGIT_W-1:0]   r_in_sr;
   logic [DIGIT_W-1:0]   r_out_sr;
   logic                 r_digit_done;
   logic [DIGIT_W-1:0]   r_digit_out;
   logic                 r_digit_err;
   logic                 r_word_done;
   logic                 r_word_err;
   logic                 r_err_acc;

   logic                 w_mode;
   logic                 w_k;
   logic                 w_z;
   logic                 w_c_nxt;
   logic                 w_last;
   logic [DIGIT_W-1:0]   w_in_nxt;
   logic [DIGIT_W-1:0]   w_out_nxt;
   logic                 w_err;

   // Bit 0 uses the live mode; later bits use the value captured at bit 0.
   assign w_mode    = (r_state == ST_IDLE) ? i_mode : r_mode;
   assign w_k       = OFFS_V[r_bit_idx];
   assign w_z       = i_x ^ w_k ^ r_carry;
   assign w_c_nxt   = w_mode ? ((i_x & w_k) | ((i_x ^ w_k) & r_carry))
                             : ((~i_x & w_k) | (~(i_x ^ w_k) & r_carry));
   assign w_in_nxt  = {i_x, r_in_sr[DIGIT_W-1:1]};
   assign w_out_nxt = {w_z, r_out_sr[DIGIT_W-1:1]};
   assign w_err     = w_mode ? ({1'b0, w_in_nxt} >= RADIX_V)
                             : (w_c_nxt | ({1'b0, w_out_nxt} >= RADIX_V));

   always_comb begin
      w_state_nxt = r_state;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_en) w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (i_en && (r_bit_idx == LAST_BIT)) begin
               w_last      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_bit_idx <= '0;
         r_carry   <= 1'b0;
         r_mode    <= 1'b0;
         r_in_sr   <= '0;
         r_out_sr  <= '0;
      end else if (i_en) begin
         r_state   <= w_state_nxt;
         r_in_sr   <= w_in_nxt;
         r_out_sr  <= w_out_nxt;
         if (r_state == ST_IDLE) r_mode <= i_mode;
         if (w_last) begin
            r_bit_idx <= '0;
            r_carry   <= 1'b0;
         end else begin
            r_bit_idx <= r_bit_idx + BIT_W'(1);
            r_carry   <= w_c_nxt;
         end
      end
   end

   // Completion flags are registered, so they appear the cycle after the last bit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_digit_idx  <= '0;
         r_digit_done <= 1'b0;
         r_digit_out  <= '0;
         r_digit_err  <= 1'b0;
         r_word_done  <= 1'b0;
         r_word_err   <= 1'b0;
         r_err_acc    <= 1'b0;
      end else begin
         r_digit_done <= w_last;
         r_digit_err  <= w_last & w_err;
         r_word_done  <= 1'b0;
         if (w_last) begin
            r_digit_out <= w_out_nxt;
            if (r_digit_idx == LAST_DIG) begin
               r_digit_idx <= '0;
               r_word_done <= 1'b1;
               r_word_err  <= r_err_acc | w_err;
               r_err_acc   <= 1'b0;
            end else begin
               r_digit_idx <= r_digit_idx + DIDX_W'(1);
               r_err_acc   <= r_err_acc | w_err;
            end
         end
      end
   end

   assign o_z          = w_z;
   assign o_bit_idx    = r_bit_idx;
   assign o_digit_idx  = r_digit_idx;
   assign o_digit_done = r_digit_done;
   assign o_digit_out  = r_digit_out;
   assign o_digit_err  = r_digit_err;
   assign o_word_done  = r_word_done;
   assign o_word_err   = r_word_err;

endmodule

// File: tb/tb_serial_digit_code_conv.sv
`timescale 1ns/1ps
// Bench for serial_digit_code_conv: directed cases plus randomized digits, checked every
// cycle against a whole-digit arithmetic model of offset add/subtract.
module tb_serial_digit_code_conv;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       mode = 1'b0;
   logic       x = 1'b0;
   logic       z;
   logic [1:0] bit_idx;
   logic [1:0] digit_idx;
   logic       digit_done;
   logic [3:0] digit_out;
   logic       digit_err;
   logic       word_done;
   logic       word_err;

   int n_vec = 0;
   int n_err = 0;

   serial_digit_code_conv dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_x(x),
      .o_z(z), .o_bit_idx(bit_idx), .o_digit_idx(digit_idx),
      .o_digit_done(digit_done), .o_digit_out(digit_out), .o_digit_err(digit_err),
      .o_word_done(word_done), .o_word_err(word_err)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: collects the digit value bit by bit, predicts each serial bit as the matching bit of
   // (partial value +/- 3), and produces the digit result with plain integer arithmetic.
   int m_bits = 0, m_in = 0, m_mode = 0, m_didx = 0, m_acc = 0;
   int e_done = 0, e_out = 0, e_err = 0, e_wdone = 0, e_werr = 0;

   always @(negedge clk) begin
      int md, partial, res, dv, derr;
      if (!rst_n) begin
         m_bits = 0; m_in = 0; m_mode = 0; m_didx = 0; m_acc = 0;
         e_done = 0; e_out = 0; e_err = 0; e_wdone = 0; e_werr = 0;
      end
      check("bit_idx", 32'(bit_idx), m_bits);
      check("digit_idx", 32'(digit_idx), m_didx);
      check("digit_done", 32'(digit_done), e_done);
      check("digit_out", 32'(digit_out), e_out);
      check("digit_err", 32'(digit_err), e_err);
      check("word_done", 32'(word_done), e_wdone);
      check("word_err", 32'(word_err), e_werr);
      e_done = 0; e_err = 0; e_wdone = 0;
      if (rst_n && en) begin
         md      = (m_bits == 0) ? int'(mode) : m_mode;
         partial = m_in | (int'(x) << m_bits);
         res     = md ? partial + 3 : partial - 3;
         check("z", 32'(z), (res >> m_bits) & 1);
         if (m_bits == 0) m_mode = md;
         m_in = partial;
         m_bits++;
         if (m_bits == 4) begin
            dv   = res & 15;
            derr = md ? int'(m_in >= 10) : int'((m_in < 3) || (dv >= 10));
            e_done = 1; e_out = dv; e_err = derr;
            m_bits = 0; m_in = 0;
            if (m_didx == 3) begin
               m_didx = 0; e_wdone = 1; e_werr = m_acc | derr; m_acc = 0;
            end else begin
               m_didx++; m_acc = m_acc | derr;
            end
         end
      end
   end

   task automatic send_bit(input logic b, input logic m);
      en = 1'b1; x = b; mode = m;
      @(posedge clk); #1;
      en = 1'b0;
   endtask

   task automatic idle(input int n);
      en = 1'b0; x = 1'($urandom); mode = 1'($urandom);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // gmax: idle cycles between bits (0..gmax, or exactly gmax when gfix); tog: first bit
   // from which the mode input is inverted (-1 = never).
   task automatic send_digit(input int v, input logic m, input int gmax, input bit gfix, input int tog);
      for (int i = 0; i < 4; i++) begin
         if (i > 0 && gmax > 0) idle(gfix ? gmax : int'($urandom_range(0, gmax)));
         send_bit(1'(v >> i), (tog >= 0 && i >= tog) ? ~m : m);
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0; en = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_digit_out", 32'(digit_out), 0);
      check("reset_bit_idx", 32'(bit_idx), 0);
      rst_n = 1'b1;
      idle(2);

      for (int v = 3; v <= 12; v++) begin
         send_digit(v, 1'b0, 0, 1'b0, -1);
         check("xs3_to_bcd", 32'(digit_out), v - 3);
      end
      for (int v = 0; v <= 9; v++) begin
         send_digit(v, 1'b1, 0, 1'b0, -1);
         check("bcd_to_xs3", 32'(digit_out), v + 3);
      end
      send_digit(5, 1'b1, 0, 1'b0, -1);
      check("lit_0101_add", 32'(digit_out), 4'b1000);
      send_digit(6, 1'b1, 0, 1'b0, -1);
      send_digit(7, 1'b1, 0, 1'b0, -1);
      send_digit(8, 1'b1, 0, 1'b0, -1);

      send_digit(2, 1'b0, 0, 1'b0, -1);
      check("lit_err_0010", 32'(digit_err), 1);
      send_digit(13, 1'b0, 0, 1'b0, -1);
      check("lit_err_1101", 32'(digit_err), 1);
      send_digit(5, 1'b0, 0, 1'b0, -1);
      send_digit(6, 1'b0, 0, 1'b0, -1);
      check("lit_word_done", 32'(word_done), 1);
      check("lit_word_err1", 32'(word_err), 1);
      for (int v = 3; v <= 6; v++) send_digit(v, 1'b0, 0, 1'b0, -1);
      check("lit_word_err0", 32'(word_err), 0);

      send_digit(7, 1'b1, 1, 1'b1, -1);
      check("lit_gap_out", 32'(digit_out), 4'b1010);
      check("lit_gap_done", 32'(digit_done), 1);
      idle(1);
      check("lit_gap_once", 32'(digit_done), 0);

      pulse_reset();
      send_digit(4, 1'b1, 0, 1'b0, -1);
      send_digit(9, 1'b0, 0, 1'b0, -1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      check("lit_pre_rst_bit", 32'(bit_idx), 2);
      rst_n = 1'b0;
      #1;
      check("lit_rst_bit", 32'(bit_idx), 0);
      check("lit_rst_digit", 32'(digit_idx), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int d = 0; d < 4; d++) send_digit(d + 3, 1'b0, 0, 1'b0, -1);
      check("lit_rst_word", 32'(word_done), 1);

      send_digit(6, 1'b0, 0, 1'b0, 2);
      check("lit_mode_kept", 32'(digit_out), 4'b0011);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 24) == 0) begin
            for (int b = 0; b < int'($urandom_range(1, 3)); b++) send_bit(1'($urandom), 1'($urandom));
            pulse_reset();
         end
         send_digit(int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 2)), 1'b0,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1);
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
